cfg_bus_sequencer: RTL and testbench
====================================

// Module: cfg_bus_sequencer
// PURPOSE
//  Shares the single config register bus between NUM_REQ requesters, e.g. host CSR port and on-chip init engine.
//  Arbitrates round-robin and issues one access at a time: a one-cycle write strobe or a read.
//  For a read it captures the registered read data from the downstream config mux and returns it with a response pulse.
//  Sits directly upstream of the config address-decode/read-mux block that fans out to MFUNC TOP/SUB1..SUB3.
// PARAMETERS
//  NUM_REQ    2   number of requesters (1..8)
//  ADDR_W     64  config address width
//  DATA_W     32  config data width
//  SUB_LSB    13  lowest address bit of the sub-block select field
//  NUM_SUB    4   number of populated sub-blocks (select values 0..NUM_SUB-1)
// PORTS
//  clk          in   1               clock
//  rst_n        in   1               async active-low reset
//  req_valid    in   NUM_REQ         per-requester access request; held until req_ready
//  req_write    in   NUM_REQ         1=write, 0=read
//  req_addr     in   NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//  req_wdata    in   NUM_REQ*DATA_W  packed write data
//  req_ready    out  NUM_REQ         one-cycle accept pulse, one-hot
//  rsp_valid    out  NUM_REQ         one-cycle completion pulse, one-hot, to the accepted requester
//  rsp_rdata    out  DATA_W          read data, valid with rsp_valid; holds last value otherwise
//  rsp_err      out  1               access error, valid with rsp_valid
//  reg_wr_en    out  1               write strobe to the config mux
//  reg_addr     out  ADDR_W          address to the config mux
//  reg_wr_data  out  DATA_W          write data to the config sub-blocks
//  reg_rd_data  in   DATA_W          registered read data from the config mux (1-cycle latency)
// BEHAVIOUR
//  Reset: all outputs 0, FSM in IDLE, round-robin pointer = 0.
//  Reset is asynchronous mid-operation: the access in flight is dropped, with no rsp_valid and no further strobe.
//  FSM states: IDLE -> ISSUE -> (RD_WAIT) -> RESP -> IDLE.
//  IDLE: if any req_valid, grant the first set bit at or after ptr, with wrap-around.
//    - Latch that requester's write/addr/wdata.
//    - Pulse req_ready[g]; set ptr = g+1 mod NUM_REQ; go to ISSUE.
//  ISSUE (1 cycle): reg_addr/reg_wr_data driven from the latch.
//    - Write: reg_wr_en=1 for exactly this cycle, then RESP.
//    - Read: reg_wr_en=0, then RD_WAIT.
//  RD_WAIT (1 cycle): reg_addr held; reg_rd_data is valid now and is captured into rsp_rdata; then RESP.
//  RESP (1 cycle): rsp_valid[g]=1 and rsp_err valid; then IDLE. No new grant in RESP.
//  Latency from req_ready to rsp_valid: write 2 cycles, read 3 cycles.
//  Throughput: one access per 3 cycles (write) or 4 cycles (read).
//  reg_addr/reg_wr_data hold their last value outside ISSUE/RD_WAIT; reg_wr_en is 0 outside ISSUE.
//  Write responses leave rsp_rdata unchanged.
//  req_valid/req_* changes after acceptance are ignored until the next IDLE.
//  Simultaneous requests: strict round-robin; no requester waits more than NUM_REQ-1 grants.
//  NUM_REQ=1: pointer is constant 0.
// CONFIGURATION
//  Macro CFG_SEQ_ADDR_CHK_EN.
//  Defined: in ISSUE, an access with addr[ADDR_W-1:SUB_LSB] >= NUM_SUB is an error.
//    - No reg_wr_en and no read.
//    - FSM goes ISSUE -> RESP directly, with rsp_err=1 and rsp_rdata=0.
//  Not defined: rsp_err is tied to 0 and every address is issued; the downstream mux default applies.
// STRUCTURE
//  Package cfg_seq_pkg holds:
//    - the state enum (IDLE, ISSUE, RD_WAIT, RESP);
//    - CFG_SUB_LSB=13 and CFG_NUM_SUB=4.
//  Sub-module cfg_rr_arb holds the NUM_REQ round-robin arbiter: req vector + ptr -> one-hot grant + index.
//  The arbiter is combinational; ptr is stored in the parent.
// TESTING
//  1. Single write: req0 write, addr=0x2004, wdata=0xA5A5_0001.
//     -> req_ready[0] at T; reg_wr_en=1, reg_addr=0x2004 at T+1; rsp_valid[0] at T+2.
//  2. Single read: req1 read, addr=0x4010, with the mux returning 0x1234_5678.
//     -> rsp_valid[1] at T+3, rsp_rdata=0x1234_5678, reg_wr_en never 1.
//  3. Contention: req0 and req1 held continuously valid for 6 accesses.
//     -> grants alternate 0,1,0,1,0,1 starting from 0 after reset.
//  4. Pointer wrap: NUM_REQ=3, only req2 and req0 valid with ptr=2.
//     -> grant 2 then 0, then ptr=1.
//  5. Reset mid-read: assert rst_n=0 during RD_WAIT.
//     -> no rsp_valid, all outputs 0; the next request is granted normally.
//  6. CFG_SEQ_ADDR_CHK_EN with write to addr 0x8000 (select 4).
//     -> no reg_wr_en; rsp_valid at T+2 with rsp_err=1.
//     -> Without the macro: reg_wr_en=1 and rsp_err=0.

Source files
------------

// File: rtl/cfg_seq_pkg.sv
// Shared state encoding and sub-block map defaults for the config bus sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cfg_seq_pkg;

   // Lowest address bit of the sub-block select field, and number of populated sub-blocks
   localparam int CFG_SUB_LSB = 13;
   localparam int CFG_NUM_SUB = 4;

   // Sequencer FSM: one access in flight, read adds a wait cycle for the registered mux
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      RD_WAIT = 2'd2,
      RESP    = 2'd3
   } seq_state_e;

   // Width of a requester index; a single requester still needs a 1-bit field
   function automatic int rr_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cfg_rr_arb.sv
// Round-robin pick of one requester; search starts at ptr and wraps around.
// Latency: combinational, zero cycles.
// Backpressure: none here; the parent decides when a grant is consumed and advances ptr.
module cfg_rr_arb
   import cfg_seq_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = rr_idx_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   gnt_idx,
   output logic               gnt_vld
);

   // Walk the requesters from ptr upward with wrap, take the first one asserted
   always_comb begin
      int               cand;
      logic [IDX_W-1:0] ci;
      gnt     = '0;
      gnt_idx = '0;
      gnt_vld = 1'b0;
      cand    = 0;
      ci      = '0;
      for (int off = 0; off < NUM_REQ; off++) begin
         cand = int'(ptr) + off;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         ci = IDX_W'(cand);
         if (!gnt_vld && req[ci]) begin
            gnt_vld  = 1'b1;
            gnt[ci]  = 1'b1;
            gnt_idx  = ci;
         end
      end
   end

endmodule

// File: rtl/cfg_bus_sequencer.sv
// Shares one config register bus between NUM_REQ requesters, one access at a time, round-robin.
// Latency: req_ready to rsp_valid is 2 cycles for a write, 3 for a read (one access per 3/4 cycles).
// Backpressure: requests hold req_valid until the one-cycle req_ready pulse; no grant outside IDLE.
// Optional address range check enabled by defining CFG_SEQ_ADDR_CHK_EN.
module cfg_bus_sequencer
   import cfg_seq_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = 64,
   parameter int DATA_W  = 32,
   parameter int SUB_LSB = CFG_SUB_LSB,
   parameter int NUM_SUB = CFG_NUM_SUB
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_write,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic                      rsp_err,
   output logic                      reg_wr_en,
   output logic [ADDR_W-1:0]         reg_addr,
   output logic [DATA_W-1:0]         reg_wr_data,
   input  logic [DATA_W-1:0]         reg_rd_data
);

   localparam int IDX_W = rr_idx_w(NUM_REQ);
   localparam int SEL_W = ADDR_W - SUB_LSB;

`ifdef CFG_SEQ_ADDR_CHK_EN
   localparam bit ADDR_CHK_EN = 1'b1;
`else
   localparam bit ADDR_CHK_EN = 1'b0;
`endif

   seq_state_e         state;
   seq_state_e         state_nxt;
   logic [IDX_W-1:0]   ptr;
   logic [IDX_W-1:0]   ptr_nxt;

   logic [NUM_REQ-1:0] gnt;
   logic [IDX_W-1:0]   gnt_idx;
   logic               gnt_vld;
   logic               take;

   logic               g_write;
   logic [ADDR_W-1:0]  g_addr;
   logic [DATA_W-1:0]  g_wdata;
   logic [SEL_W-1:0]   g_sel;
   logic               addr_bad;

   // Access latched at grant time; later changes on req_* are ignored until IDLE
   logic [NUM_REQ-1:0] lat_gnt;
   logic               lat_write;
   logic               lat_err;

   cfg_rr_arb #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_arb (
      .req     (req_valid),
      .ptr     (ptr),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_vld (gnt_vld)
   );

   // A grant is consumed only in IDLE; held low while reset is asserted
   assign take      = (state == IDLE) && gnt_vld;
   assign req_ready = (take && rst_n) ? gnt : '0;

   // Select the granted requester's command fields
   always_comb begin
      g_write = 1'b0;
      g_addr  = '0;
      g_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_idx == IDX_W'(i)) begin
            g_write = req_write[i];
            g_addr  = req_addr[i*ADDR_W +: ADDR_W];
            g_wdata = req_wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   // Sub-block select out of range is an error only when the range check is built in
   assign g_sel    = g_addr[ADDR_W-1:SUB_LSB];
   assign addr_bad = ADDR_CHK_EN && (g_sel >= SEL_W'(NUM_SUB));

   // Pointer moves to the requester after the one just granted, wrapping to 0
   always_comb begin
      if (gnt_idx == IDX_W'(NUM_REQ-1)) begin
         ptr_nxt = '0;
      end else begin
         ptr_nxt = gnt_idx + IDX_W'(1);
      end
   end

   // Next-state: errored or write accesses skip the read wait cycle
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (gnt_vld) state_nxt = ISSUE;
         ISSUE:   state_nxt = (lat_write || lat_err) ? RESP : RD_WAIT;
         RD_WAIT: state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Latch the granted access and advance the round-robin pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr       <= '0;
         lat_gnt   <= '0;
         lat_write <= 1'b0;
         lat_err   <= 1'b0;
      end else if (take) begin
         ptr       <= ptr_nxt;
         lat_gnt   <= gnt;
         lat_write <= g_write;
         lat_err   <= addr_bad;
      end
   end

   // Drive the config bus: address/data registered into ISSUE, strobe for ISSUE only
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg_wr_en   <= 1'b0;
         reg_addr    <= '0;
         reg_wr_data <= '0;
      end else begin
         reg_wr_en <= 1'b0;
         if (take && !addr_bad) begin
            reg_addr    <= g_addr;
            reg_wr_data <= g_wdata;
            reg_wr_en   <= g_write;
         end
      end
   end

   // Response: one-cycle pulse in RESP, read data captured from the registered mux in RD_WAIT
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= '0;
         rsp_err   <= 1'b0;
         case (state)
            ISSUE: begin
               if (lat_err) begin
                  rsp_valid <= lat_gnt;
                  rsp_err   <= 1'b1;
                  rsp_rdata <= '0;
               end else if (lat_write) begin
                  rsp_valid <= lat_gnt;
               end
            end
            RD_WAIT: begin
               rsp_valid <= lat_gnt;
               rsp_rdata <= reg_rd_data;
            end
            default: begin
               rsp_valid <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cfg_bus_sequencer.sv
// Self-checking bench for cfg_bus_sequencer: directed steps followed by random traffic.
// Expected values come from a transaction-level model (pointer, memory, last read data).
// Runs a second 3-requester instance for the pointer wrap case.
module tb_cfg_bus_sequencer;

   localparam int NREQ = 2;
   localparam int AW   = 64;
   localparam int DW   = 32;

`ifdef CFG_SEQ_ADDR_CHK_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [NREQ-1:0]    req_valid, req_write, req_ready, rsp_valid;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*DW-1:0] req_wdata;
   logic [DW-1:0]      rsp_rdata, reg_wr_data, reg_rd_data;
   logic               rsp_err, reg_wr_en;
   logic [AW-1:0]      reg_addr;

   cfg_bus_sequencer #(.NUM_REQ(NREQ)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .reg_wr_en(reg_wr_en), .reg_addr(reg_addr), .reg_wr_data(reg_wr_data), .reg_rd_data(reg_rd_data)
   );

   logic [2:0]     v3, w3, rdy3, rspv3;
   logic [3*AW-1:0] a3;
   logic [3*DW-1:0] d3;
   logic [DW-1:0]  rdata3, wdata3, rd3;
   logic           err3, wen3;
   logic [AW-1:0]  addr3;

   cfg_bus_sequencer #(.NUM_REQ(3)) dut3 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(v3), .req_write(w3), .req_addr(a3), .req_wdata(d3),
      .req_ready(rdy3), .rsp_valid(rspv3), .rsp_rdata(rdata3), .rsp_err(err3),
      .reg_wr_en(wen3), .reg_addr(addr3), .reg_wr_data(wdata3), .reg_rd_data(rd3)
   );

   // Default contents of never-written config registers
   function automatic logic [31:0] dflt(input logic [63:0] a);
      return a[31:0] ^ a[63:32] ^ 32'hC0DE_0000;
   endfunction

   // Downstream config mux: registered read data, write on strobe (read before write)
   logic [31:0] mux_mem [logic [63:0]];
   always @(posedge clk) begin
      reg_rd_data <= mux_mem.exists(reg_addr) ? mux_mem[reg_addr] : dflt(reg_addr);
      if (reg_wr_en) mux_mem[reg_addr] = reg_wr_data;
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model state
   int          mptr;
   logic [31:0] last_rdata;
   logic [63:0] last_addr;
   logic [31:0] ref_mem [logic [63:0]];
   bit          pend [NREQ];
   bit          pw   [NREQ];
   logic [63:0] pa   [NREQ];
   logic [31:0] pd   [NREQ];
   int          obs_g;

   function automatic bit is_err(input logic [63:0] a);
      return CHK_EN && ((a >> 13) >= 64'd4);
   endfunction

   function automatic logic [31:0] ref_read(input logic [63:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
   endfunction

   function automatic int model_grant();
      for (int off = 0; off < NREQ; off++)
         if (pend[(mptr + off) % NREQ]) return (mptr + off) % NREQ;
      return 0;
   endfunction

   function automatic logic [63:0] rand_addr();
      logic [63:0] a;
      a = (64'($urandom_range(0, 5)) << 13) | 64'($urandom_range(0, 7) * 4);
      if ($urandom_range(0, 9) == 0) a[45] = 1'b1;
      return a;
   endfunction

   task automatic set_req(input int i, input bit w, input logic [63:0] a, input logic [31:0] d);
      pend[i] = 1'b1; pw[i] = w; pa[i] = a; pd[i] = d;
   endtask

   task automatic drive();
      for (int i = 0; i < NREQ; i++) begin
         req_valid[i]            = pend[i];
         req_write[i]            = pw[i];
         req_addr[i*AW +: AW]    = pa[i];
         req_wdata[i*DW +: DW]   = pd[i];
      end
   endtask

   // Top up idle requesters with random accesses; always leave at least one pending
   task automatic refill();
      int any;
      any = 0;
      for (int i = 0; i < NREQ; i++) begin
         if (!pend[i] && $urandom_range(0, 3) != 0)
            set_req(i, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
         if (pend[i]) any = 1;
      end
      if (any == 0) set_req($urandom_range(0, NREQ-1), 1'($urandom_range(0, 1)), rand_addr(), $urandom);
   endtask

   // One access from grant to response; entered and left at a negedge with the DUT idle
   task automatic run_txn();
      int g, k;
      bit err, w;
      logic [63:0] a;
      drive();
      #1;
      k = 0;
      while (req_ready == '0 && k < 8) begin @(negedge clk); k++; end
      chk("grant_latency", 64'(k), 64'd0);
      g = model_grant();
      obs_g = -1;
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) obs_g = i;
      chk("req_ready", 64'(req_ready), 64'(1) << g);
      mptr = (g + 1) % NREQ;
      w = pw[g]; a = pa[g]; err = is_err(a);
      // ISSUE
      @(negedge clk);
      pend[g] = 1'b0;
      drive();
      #1;
      chk("issue_wr_en", 64'(reg_wr_en), 64'(w && !err));
      if (!err) chk("issue_addr", reg_addr, a);
      if (w && !err) chk("issue_wdata", 64'(reg_wr_data), 64'(pd[g]));
      chk("issue_rsp_quiet", 64'(rsp_valid), 64'd0);
      chk("issue_rdata_hold", 64'(rsp_rdata), 64'(last_rdata));
      if (!err) last_addr = a;
      if (!w && !err) begin
         @(negedge clk);
         chk("rdwait_wr_en", 64'(reg_wr_en), 64'd0);
         chk("rdwait_addr", reg_addr, a);
         chk("rdwait_rsp_quiet", 64'(rsp_valid), 64'd0);
      end
      // RESP
      @(negedge clk);
      #1;
      chk("rsp_valid", 64'(rsp_valid), 64'(1) << g);
      chk("rsp_err", 64'(rsp_err), 64'(err));
      chk("resp_wr_en", 64'(reg_wr_en), 64'd0);
      chk("resp_no_grant", 64'(req_ready), 64'd0);
      if (err) last_rdata = 32'd0;
      else if (!w) last_rdata = ref_read(a);
      chk("rsp_rdata", 64'(rsp_rdata), 64'(last_rdata));
      chk("resp_addr_hold", reg_addr, last_addr);
      if (w && !err) ref_mem[a] = pd[g];
      // back to IDLE
      @(negedge clk);
      chk("idle_rsp_quiet", 64'(rsp_valid), 64'd0);
   endtask

   task automatic wait3(output logic [2:0] g);
      int k;
      k = 0;
      while (rdy3 == 3'b000 && k < 10) begin @(negedge clk); k++; end
      chk("wrap_wait_bound", 64'(k < 10), 64'd1);
      g = rdy3;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
      chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
      chk({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
      chk({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
      chk({tag, "_reg_wr_en"}, 64'(reg_wr_en), 64'd0);
      chk({tag, "_reg_addr"}, reg_addr, 64'd0);
      chk({tag, "_reg_wr_data"}, 64'(reg_wr_data), 64'd0);
   endtask

   initial begin
      logic [2:0] g3;
      for (int i = 0; i < NREQ; i++) begin pend[i] = 0; pw[i] = 0; pa[i] = '0; pd[i] = '0; end
      drive();
      v3 = '0; w3 = 3'b111; a3 = '0; d3 = '0; rd3 = '0;
      mptr = 0; last_rdata = '0; last_addr = '0;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Single write from requester 0
      set_req(0, 1'b1, 64'h2004, 32'hA5A5_0001);
      run_txn();

      // Single read from requester 1 with a known mux value
      mux_mem[64'h4010] = 32'h1234_5678;
      ref_mem[64'h4010] = 32'h1234_5678;
      set_req(1, 1'b0, 64'h4010, 32'h0);
      run_txn();

      // Contention: both requesters valid, grants must alternate from 0
      for (int k = 0; k < 6; k++) begin
         for (int i = 0; i < NREQ; i++)
            if (!pend[i]) set_req(i, 1'($urandom_range(0, 1)), 64'h2000 + 64'(4 * k), $urandom);
         run_txn();
         chk("rr_order", 64'(obs_g), 64'(k % 2));
      end
      run_txn();

      // Asynchronous reset during a read wait cycle
      set_req(0, 1'b0, 64'h2008, 32'h0);
      drive();
      #1;
      chk("rst_pre_grant", 64'(req_ready), 64'b01);
      @(negedge clk);
      pend[0] = 1'b0;
      drive();
      @(negedge clk);
      chk("rst_pre_rdwait_addr", reg_addr, 64'h2008);
      rst_n = 1'b0;
      #1;
      chk_all_zero("midreset");
      repeat (3) begin
         @(negedge clk);
         chk("midreset_no_rsp", 64'(rsp_valid), 64'd0);
      end
      rst_n = 1'b1;
      mptr = 0; last_rdata = '0; last_addr = '0;
      @(negedge clk);
      chk("post_rst_rsp_quiet", 64'(rsp_valid), 64'd0);
      chk("post_rst_wr_en", 64'(reg_wr_en), 64'd0);
      set_req(0, 1'b0, 64'h2008, 32'h0);
      set_req(1, 1'b1, 64'h600C, 32'h5555_AAAA);
      run_txn();
      chk("post_rst_grant", 64'(obs_g), 64'd0);
      run_txn();

      // Write to sub-block select 4
      set_req(0, 1'b1, 64'h8000, 32'hDEAD_BEEF);
      run_txn();

      // Random traffic against the model
      for (int n = 0; n < 60; n++) begin
         refill();
         run_txn();
      end
      for (int n = 0; n < NREQ; n++) begin
         if (pend[0] || pend[1]) run_txn();
      end

      // Pointer wrap on a 3-requester instance
      v3 = 3'b010;
      #1;
      wait3(g3);
      chk("wrap_first", 64'(g3), 64'b010);
      @(negedge clk);
      v3 = 3'b101;
      #1;
      wait3(g3);
      chk("wrap_req2", 64'(g3), 64'b100);
      @(negedge clk);
      v3 = 3'b001;
      #1;
      wait3(g3);
      chk("wrap_req0", 64'(g3), 64'b001);
      @(negedge clk);
      v3 = 3'b111;
      #1;
      wait3(g3);
      chk("wrap_ptr1", 64'(g3), 64'b010);
      @(negedge clk);
      v3 = 3'b000;
      repeat (4) @(negedge clk);
      #1;
      chk("u3_rsp_quiet", 64'(rspv3), 64'd0);
      chk("u3_wr_en", 64'(wen3), 64'd0);
      chk("u3_err", 64'(err3), 64'd0);
      chk("u3_rdata", 64'(rdata3), 64'd0);
      chk("u3_addr", addr3, 64'd0);
      chk("u3_wdata", 64'(wdata3), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
